jt7759_feed: RTL and testbench
==============================

// Module: jt7759_feed
// PURPOSE
//  Host-side master for the JT7759 slave mode (mdn=0): issues the phrase-select/start
//  sequence, then answers every drqn request by fetching the next byte from a byte
//  source and strobing it in on wrn/din. Sits between a sound CPU/ROM arbiter and
//  jt7759, replacing CPU-driven byte feeding in cores with no spare CPU time.
// PARAMETERS
//  AW      17   byte-source address width
//  WR_DLY  20   cen ticks from sampled drqn=0 to wrn falling (31.3us @640kHz)
//  ST_W    2    cen ticks stn is held low during the start sequence
//  TOUT    4095 cen ticks watchdog for drqn/busyn waits (JT7759_FEED_TOUT_EN only)
// PORTS
//  clk       in   1   system clock, same as jt7759
//  rstn      in   1   asynchronous reset, active low
//  cen       in   1   640kHz clock enable, same as jt7759 cen
//  start     in   1   1-clk pulse: begin a phrase; accepted in IDLE only
//  phrase    in   8   phrase number, sampled with start
//  base      in   AW  first source byte address, sampled with start
//  len       in   AW  data bytes to send after the phrase number, sampled with start
//  busy      out  1   high from clk after accepted start until return to IDLE
//  done      out  1   1-clk pulse on normal completion
//  err       out  1   1-clk pulse on watchdog expiry
//  mdn       out  1   to jt7759 mdn
//  cs        out  1   to jt7759 cs
//  stn       out  1   to jt7759 stn
//  wrn       out  1   to jt7759 wrn
//  dout      out  8   to jt7759 din
//  drqn      in   1   from jt7759 drqn
//  busyn     in   1   from jt7759 busyn
//  src_cs    out  1   byte-source request, held until src_ok
//  src_addr  out  AW  byte-source address
//  src_data  in   8   byte-source data, valid when src_ok=1
//  src_ok    in   1   byte-source acknowledge
// BEHAVIOUR
//  - Reset (async, rstn=0): state IDLE; mdn=1 cs=0 stn=1 wrn=1 dout=0 busy=0 done=0
//    err=0 src_cs=0 src_addr=0; all counters 0. Outputs forced immediately.
//  - All protocol timing advances on clk edges with cen=1; start/src_ok/done/err on clk.
//  - IDLE: start=1 -> latch phrase/base/len, busy=1, mdn=0 (mdn stays 0 until rstn),
//    cs=1, dout=phrase, go START. start in any other state is ignored.
//  - START: stn=0 for ST_W cen ticks, then stn=1; go WAIT_END if len=0, else FETCH.
//  - FETCH: src_cs=1, src_addr=base+sent; on src_ok latch src_data, src_cs=0 same clk.
//    Fetch overlaps WAIT_DRQ/DELAY (prefetch); at most one byte buffered.
//  - WAIT_DRQ: on cen with drqn=0 reset delay counter, go DELAY.
//  - DELAY: count WR_DLY cen ticks; at expiry, if byte latched: dout=byte, go WRITE;
//    else wait, write on first cen after src_ok (never write stale data).
//  - WRITE: wrn=0 for exactly 1 cen tick, dout stable across it; sent+=1; go HOLD.
//  - HOLD: wrn=1; wait cen with drqn=1; sent==len -> WAIT_END else FETCH.
//  - WAIT_END: wait cen with busyn=1 -> cs=0, done pulse, busy=0, IDLE.
//  - sent counter is AW bits; base+sent wraps modulo 2^AW silently.
//  - drqn already low on entering WAIT_DRQ counts as a new request.
// CONFIGURATION
//  JT7759_FEED_TOUT_EN defined: watchdog counts cen ticks spent in WAIT_DRQ, HOLD or
//  WAIT_END, cleared on every state change; reaching TOUT -> cs=0 stn=1 wrn=1
//  src_cs=0, err pulse, busy=0, IDLE. mdn stays 0.
//  Undefined: no watchdog, err tied 0, block waits indefinitely; TOUT unused.
// TESTING
//  1 rstn=0 -> mdn=1 cs=0 stn=1 wrn=1 busy=0 src_cs=0; rstn=0 mid-WRITE -> wrn=1 at once
//  2 start phrase=0x05 base=0x100 len=3, model drops drqn 3x -> stn low 2 cen, dout=0x05;
//    bytes @0x100..0x102 written, each wrn fall exactly 20 cen after drqn sample; done
//    after busyn=1
//  3 src_ok delayed 40 cen past drqn -> wrn falls on first cen after src_ok, data correct
//  4 len=0 -> phrase start only, zero wrn pulses, done after busyn=1
//  5 TOUT_EN, drqn never falls, TOUT=1000 -> err at 1000 cen, cs=0, IDLE; macro off ->
//    stays in WAIT_DRQ
//  6 start pulse while busy / base=0x1FFFF len=2 -> ignored / reads 0x1FFFF then 0x00000

Source files
------------

// File: rtl/jt7759_feed_if.sv
// Bus between jt7759_feed and its two neighbours: the JT7759 slave-mode pins and the byte source.
// The master modport is the feeder side; the slave modport is the chip/source side.
interface jt7759_feed_if #(
    parameter int AW = 17
);
    logic          mdn;
    logic          cs;
    logic          stn;
    logic          wrn;
    logic [7:0]    dout;
    logic          drqn;
    logic          busyn;
    logic          src_cs;
    logic [AW-1:0] src_addr;
    logic [7:0]    src_data;
    logic          src_ok;

    modport master (
        output mdn, cs, stn, wrn, dout, src_cs, src_addr,
        input  drqn, busyn, src_data, src_ok
    );

    modport slave (
        input  mdn, cs, stn, wrn, dout, src_cs, src_addr,
        output drqn, busyn, src_data, src_ok
    );
endinterface

// File: rtl/jt7759_feed.sv
// Host-side master for JT7759 slave mode: sends phrase/start, then answers each drqn with a fetched byte.
// Define JT7759_FEED_TOUT_EN to add a watchdog on the drqn/busyn waits (err pulse on expiry).
module jt7759_feed #(
    parameter int AW     = 17,
    parameter int WR_DLY = 20,
    parameter int ST_W   = 2,
    parameter int TOUT   = 4095
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cen,
    input  logic          start,
    input  logic [7:0]    phrase,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    jt7759_feed_if.master bus
);
    localparam int TMAX = (WR_DLY > ST_W) ? WR_DLY : ST_W;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, START, FETCH, WAIT_DRQ, DELAY, WRITE, HOLD, WAIT_END
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tmr;
    logic [AW-1:0] base_q, len_q, sent, src_addr;
    logic [7:0]    byte_q, dout;
    logic          byte_vld, src_cs, mdn, timeout, wd_end, dly_end;

    assign dly_end = tmr >= TW'(WR_DLY - 1);

    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        case (state)
            IDLE:     if (start) state_nx = START;
            START:    if (cen && tmr == TW'(ST_W - 1))
                          state_nx = (len_q == '0) ? WAIT_END : FETCH;
            FETCH:    state_nx = WAIT_DRQ;
            WAIT_DRQ: if (cen && !bus.drqn) state_nx = DELAY;
            // Hold off past the delay until the byte is really latched: no stale writes
            DELAY:    if (cen && dly_end && byte_vld) state_nx = WRITE;
            WRITE:    if (cen) state_nx = HOLD;
            HOLD:     if (cen && bus.drqn)
                          state_nx = (sent == len_q) ? WAIT_END : FETCH;
            WAIT_END: if (cen && bus.busyn) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (wd_end && state_nx == state) begin
            state_nx = IDLE;
            timeout  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tmr      <= '0;
            mdn      <= 1'b1;
            dout     <= 8'd0;
            base_q   <= '0;
            len_q    <= '0;
            sent     <= '0;
            src_cs   <= 1'b0;
            src_addr <= '0;
            byte_q   <= 8'd0;
            byte_vld <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == WAIT_END) && (state_nx == IDLE) && !timeout;
            if (state_nx != state)
                tmr <= '0;
            else if (cen && (state == START || (state == DELAY && !dly_end)))
                tmr <= tmr + 1'b1;
            if (state == IDLE && start) begin
                mdn      <= 1'b0;
                dout     <= phrase;
                base_q   <= base;
                len_q    <= len;
                sent     <= '0;
                byte_vld <= 1'b0;
            end
            // Single-entry prefetch buffer, filled while waiting for drqn
            if (state == FETCH) begin
                src_cs   <= 1'b1;
                src_addr <= base_q + sent;
            end else if (src_cs && bus.src_ok) begin
                src_cs   <= 1'b0;
                byte_q   <= bus.src_data;
                byte_vld <= 1'b1;
            end
            if (state == DELAY && state_nx == WRITE) begin
                dout     <= byte_q;
                byte_vld <= 1'b0;
            end
            if (state == WRITE && state_nx == HOLD)
                sent <= sent + 1'b1;
            if (timeout) begin
                src_cs   <= 1'b0;
                byte_vld <= 1'b0;
            end
        end
    end

`ifdef JT7759_FEED_TOUT_EN
    localparam int WDW = $clog2(TOUT + 1);
    logic [WDW-1:0] wd;
    logic           wd_run, err_q;

    assign wd_run = (state == WAIT_DRQ) || (state == HOLD) || (state == WAIT_END);
    assign wd_end = wd_run && cen && (wd == WDW'(TOUT - 1));
    assign err    = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state_nx != state)
                wd <= '0;
            else if (cen && wd_run)
                wd <= wd + 1'b1;
        end
    end
`else
    logic unused_tout;
    assign unused_tout = (TOUT != 0);
    assign wd_end      = 1'b0;
    assign err         = 1'b0;
`endif

    assign busy         = (state != IDLE);
    assign bus.mdn      = mdn;
    assign bus.cs       = (state != IDLE);
    assign bus.stn      = (state != START);
    assign bus.wrn      = (state != WRITE);
    assign bus.dout     = dout;
    assign bus.src_cs   = src_cs;
    assign bus.src_addr = src_addr;
endmodule

// File: tb/tb_jt7759_feed.sv
// Randomized bench for jt7759_feed: behavioural JT7759 slave + byte source, timing checked in cen ticks.
`timescale 1ns/1ps
module tb_jt7759_feed;
    localparam int AW     = 17;
    localparam int WR_DLY = 20;
    localparam int ST_W   = 2;
    localparam int TOUT   = 1000;

    logic          clk = 1'b0, rstn = 1'b1, cen = 1'b0, start = 1'b0;
    logic [7:0]    phrase = 8'd0;
    logic [AW-1:0] base = '0, len = '0;
    logic          busy, done, err;
    logic          drqn = 1'b1, busyn = 1'b1, src_ok = 1'b0;
    logic [7:0]    src_data = 8'd0, seed = 8'd0;

    int n_tests = 0, n_fail = 0, cyc = 0, cen_cnt = 0;
    logic was_cen = 1'b0;

    jt7759_feed_if #(.AW(AW)) bus ();

    assign bus.drqn     = drqn;
    assign bus.busyn    = busyn;
    assign bus.src_data = src_data;
    assign bus.src_ok   = src_ok;

    jt7759_feed #(.AW(AW), .WR_DLY(WR_DLY), .ST_W(ST_W), .TOUT(TOUT)) dut (
        .clk(clk), .rstn(rstn), .cen(cen), .start(start), .phrase(phrase),
        .base(base), .len(len), .busy(busy), .done(done), .err(err), .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte source contents: a fixed scramble of the address, re-keyed per phrase
    function automatic logic [7:0] mem(input logic [AW-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd37 + (32'(a) >> 8);
        return t[7:0] ^ seed;
    endfunction

    // One clock; inputs change and outputs are sampled 1ns after the edge; cen every 4th edge
    task automatic step();
        was_cen = cen;
        @(posedge clk);
        #1;
        if (was_cen) cen_cnt++;
        cyc++;
        cen = (cyc % 4 == 0);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_mdn"}, 32'(bus.mdn), 32'd1);
        check_eq({tag, "_cs"}, 32'(bus.cs), 32'd0);
        check_eq({tag, "_stn"}, 32'(bus.stn), 32'd1);
        check_eq({tag, "_wrn"}, 32'(bus.wrn), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_src_cs"}, 32'(bus.src_cs), 32'd0);
    endtask

    // mode 0: normal, 1: async reset during the first write, 2: extra start while busy
    task automatic run_phrase(input logic [7:0] ph, input logic [AW-1:0] b,
                              input logic [AW-1:0] n, input int lat, input int mode);
        int  k, fetched, stn_low, req_idx, ok_after, lat_cnt, wr_low, drq_at, end_at, busy_at, exp_t;
        bit  req_pend, drq_arm, end_arm, busy_pend, fin, stn_prev, wrn_prev, err_seen;
        logic drqn_e, busyn_e, ok_e;
        k = 0; fetched = 0; stn_low = 0; req_idx = 0; ok_after = 0; lat_cnt = 0; wr_low = 0;
        drq_at = 0; end_at = 0; busy_at = -1;
        req_pend = 0; drq_arm = 0; end_arm = 0; busy_pend = 0; fin = 0; err_seen = 0;
        drqn = 1'b1; busyn = 1'b1; src_ok = 1'b0;
        phrase = ph; base = b; len = n; start = 1'b1;
        step();
        start = 1'b0; phrase = ~ph; base = ~b; len = ~n;
        busyn = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_mdn", 32'(bus.mdn), 32'd0);
        check_eq("start_cs", 32'(bus.cs), 32'd1);
        check_eq("start_dout", 32'(bus.dout), 32'(ph));
        stn_prev = bus.stn; wrn_prev = bus.wrn;
        for (int i = 0; i < 20000 && !fin; i++) begin
            drqn_e = drqn; busyn_e = busyn; ok_e = src_ok;
            step();
            if (err) err_seen = 1;
            if (start) begin
                start = 1'b0;
                check_eq("ignored_start_busy", 32'(busy), 32'd1);
                check_eq("ignored_start_dout", 32'(bus.dout), 32'(ph));
            end
            if (was_cen && !stn_prev) stn_low++;
            if (!stn_prev && bus.stn) begin
                check_eq("stn_low_ticks", 32'(stn_low), 32'(ST_W));
                if (n == 0) begin end_arm = 1; end_at = cen_cnt + $urandom_range(1, 6); end
                else begin drq_arm = 1; drq_at = cen_cnt + $urandom_range(1, 5); end
                if (mode == 2) begin phrase = 8'hAA; base = 17'h00055; len = 17'd5; start = 1'b1; end
            end
            if (was_cen && req_pend && !drqn_e) begin req_idx = cen_cnt; req_pend = 0; end
            if (drq_arm && cen_cnt >= drq_at) begin drqn = 1'b0; drq_arm = 0; req_pend = 1; end
            if (ok_e) begin
                ok_after = cen_cnt + 1;
                src_ok = 1'b0;
                check_eq("src_cs_release", 32'(bus.src_cs), 32'd0);
            end else if (bus.src_cs && !src_ok) begin
                if (lat_cnt == 0)
                    check_eq("src_addr", 32'(bus.src_addr), 32'(AW'(b + AW'(fetched))));
                if (lat_cnt >= lat) begin
                    src_ok = 1'b1; src_data = mem(bus.src_addr); fetched++; lat_cnt = 0;
                end else lat_cnt++;
            end
            if (!wrn_prev && was_cen) wr_low++;
            if (wrn_prev && !bus.wrn) begin
                exp_t = (req_idx + WR_DLY > ok_after) ? req_idx + WR_DLY : ok_after;
                check_eq("wr_time", 32'(cen_cnt), 32'(exp_t));
                check_eq("wr_data", 32'(bus.dout), 32'(mem(AW'(b + AW'(k)))));
                drqn = 1'b1; wr_low = 0;
                if (mode == 1) begin
                    rstn = 1'b0;
                    #1;
                    check_reset("rst_in_write");
                    fin = 1;
                end
            end
            if (!wrn_prev && !bus.wrn)
                check_eq("wr_dout_stable", 32'(bus.dout), 32'(mem(AW'(b + AW'(k)))));
            if (!wrn_prev && bus.wrn) begin
                check_eq("wr_width", 32'(wr_low), 32'd1);
                k++;
                if (k < int'(n)) begin drq_arm = 1; drq_at = cen_cnt + $urandom_range(1, 5); end
                else begin end_arm = 1; end_at = cen_cnt + $urandom_range(1, 6); end
            end
            if (was_cen && busy_pend && busyn_e) begin busy_at = cen_cnt; busy_pend = 0; end
            if (end_arm && cen_cnt >= end_at) begin busyn = 1'b1; end_arm = 0; busy_pend = 1; end
            if (done && mode != 1) begin
                check_eq("done_time", 32'(cen_cnt), 32'(busy_at));
                check_eq("bytes_written", 32'(k), 32'(n));
                check_eq("done_cs", 32'(bus.cs), 32'd0);
                check_eq("done_busy", 32'(busy), 32'd0);
                fin = 1;
            end
            stn_prev = bus.stn; wrn_prev = bus.wrn;
        end
        if (!fin) check_eq("phrase_timeout", 32'd0, 32'd1);
        if (mode != 1) begin
            step();
            check_eq("done_pulse", 32'(done), 32'd0);
            check_eq("no_err", 32'(err_seen), 32'd0);
        end
    endtask

    task automatic run_tout();
        int rise_idx, err_idx;
        bit stn_prev, err_seen;
        rise_idx = -1; err_idx = -1; err_seen = 0;
        drqn = 1'b1; busyn = 1'b0; src_ok = 1'b0;
        phrase = 8'h33; base = 17'h00200; len = 17'd2; start = 1'b1;
        step();
        start = 1'b0;
        stn_prev = bus.stn;
        for (int i = 0; i < (TOUT + 150) * 4; i++) begin
            step();
            if (src_ok) src_ok = 1'b0;
            else if (bus.src_cs) begin src_ok = 1'b1; src_data = mem(bus.src_addr); end
            if (!stn_prev && bus.stn && rise_idx < 0) rise_idx = cen_cnt;
            stn_prev = bus.stn;
            if (err) begin err_seen = 1; if (err_idx < 0) err_idx = cen_cnt; end
            if (rise_idx >= 0 && cen_cnt >= rise_idx + TOUT + 100) break;
        end
`ifdef JT7759_FEED_TOUT_EN
        check_eq("tout_time", 32'(err_idx), 32'(rise_idx + TOUT));
        check_eq("tout_cs", 32'(bus.cs), 32'd0);
        check_eq("tout_busy", 32'(busy), 32'd0);
        check_eq("tout_src_cs", 32'(bus.src_cs), 32'd0);
        check_eq("tout_stn", 32'(bus.stn), 32'd1);
        check_eq("tout_wrn", 32'(bus.wrn), 32'd1);
        check_eq("tout_mdn", 32'(bus.mdn), 32'd0);
`else
        check_eq("no_tout_err", 32'(err_seen), 32'd0);
        check_eq("no_tout_busy", 32'(busy), 32'd1);
        check_eq("no_tout_cs", 32'(bus.cs), 32'd1);
`endif
        drqn = 1'b1; busyn = 1'b1; src_ok = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        #2 rstn = 1'b0;
        #1;
        check_reset("reset");
        check_eq("reset_dout", 32'(bus.dout), 32'd0);
        check_eq("reset_src_addr", 32'(bus.src_addr), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        repeat (3) step();
        rstn = 1'b1;
        step();

        seed = 8'h00;
        run_phrase(8'h05, 17'h00100, 17'd3, 0, 0);
        seed = 8'h5A;
        run_phrase(8'h21, 17'h00400, 17'd2, 200, 0);
        run_phrase(8'h42, 17'h00000, 17'd0, 0, 0);
        run_phrase(8'h77, 17'h1FFFF, 17'd2, 1, 2);
        for (int r = 0; r < 10; r++) begin
            seed = 8'($urandom);
            run_phrase(8'($urandom), AW'($urandom), AW'($urandom_range(0, 4)),
                       $urandom_range(0, 12), 0);
        end

        run_phrase(8'h19, 17'h01000, 17'd3, 2, 1);
        drqn = 1'b1; busyn = 1'b1; src_ok = 1'b0;
        do_reset();
        check_reset("after_abort");

        run_tout();
        do_reset();
        check_reset("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
